// File: rtl/display_scan.sv
// Four-digit seven-segment scanner: walks the anodes, shows one frame-captured
// BCD digit per anode, and blinks the selected digit pair while in adjust mode.
module display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic       adj,
    input  logic       sel_pair,
    output logic [3:0] numb,
    output logic       blank,
    output logic [3:0] an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

    logic          run_q,  run_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    idx_q,  idx_d;
    logic [3:0]    sh_q [4];
    logic [3:0]    sh_d [4];
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          ph_q,   ph_d;
    logic          pair_hit_s;

    // Scan sequencing: start-up capture, per-digit dwell, frame-boundary capture.
    always_comb begin
        run_d  = run_q;
        rcnt_d = rcnt_q;
        idx_d  = idx_q;
        for (int i = 0; i < 4; i++) begin
            sh_d[i] = sh_q[i];
        end
        if (!run_q) begin
            run_d   = 1'b1;
            rcnt_d  = '0;
            idx_d   = 2'd0;
            sh_d[0] = digit0;
            sh_d[1] = digit1;
            sh_d[2] = digit2;
            sh_d[3] = digit3;
        end else if (rcnt_q == RCNT_LAST) begin
            rcnt_d = '0;
            idx_d  = idx_q + 2'd1;
            // Inputs are only sampled here so a frame never mixes old and new digits.
            if (idx_q == 2'd3) begin
                sh_d[0] = digit0;
                sh_d[1] = digit1;
                sh_d[2] = digit2;
                sh_d[3] = digit3;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end else begin
            rcnt_d = rcnt_q + RW'(1);
        end
    end

    // Blink timebase: free-runs only while adjusting, restarts visible on entry.
    always_comb begin
        bcnt_d = bcnt_q;
        ph_d   = ph_q;
        if (!adj) begin
            bcnt_d = '0;
            ph_d   = 1'b0;
        end else if (bcnt_q == BCNT_LAST) begin
            bcnt_d = '0;
            ph_d   = ~ph_q;
        end else begin
            bcnt_d = bcnt_q + BW'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            rcnt_q <= '0;
            idx_q  <= 2'd0;
            bcnt_q <= '0;
            ph_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sh_q[i] <= 4'd0;
            end
        end else begin
            run_q  <= run_d;
            rcnt_q <= rcnt_d;
            idx_q  <= idx_d;
            bcnt_q <= bcnt_d;
            ph_q   <= ph_d;
            for (int i = 0; i < 4; i++) begin
                sh_q[i] <= sh_d[i];
            end
        end
    end

    // Display drive; adj and sel_pair act combinationally on blanking.
    always_comb begin
        an         = 4'b1111;
        numb       = 4'd0;
        pair_hit_s = sel_pair ? idx_q[1] : ~idx_q[1];
        blank      = ~run_q | (adj & ph_q & pair_hit_s);
        if (run_q) begin
            case (idx_q)
                2'd0: begin an = 4'b1110; numb = sh_q[0]; end
                2'd1: begin an = 4'b1101; numb = sh_q[1]; end
                2'd2: begin an = 4'b1011; numb = sh_q[2]; end
                2'd3: begin an = 4'b0111; numb = sh_q[3]; end
                default: begin an = 4'b1111; numb = 4'd0; end
            endcase
        end else begin
            an   = 4'b1111;
            numb = 4'd0;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with REFRESH_DIV=4, BLINK_DIV=8: a vector
// table for reset/start/scan order, then hand sequences for the corner cases.
module tb_display_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] dig = 16'h1234;
    logic        adj = 1'b0;
    logic        sel_pair = 1'b0;
    logic [3:0]  numb;
    logic        blank;
    logic [3:0]  an;

    int total = 0;
    int bad = 0;

    // Reference state: scan edges since start, adj-high edges, captured digits.
    logic       run_m = 1'b0;
    int         se = 0;
    int         bc = 0;
    logic [3:0] sh_m [4];

    display_scan #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .digit0(dig[3:0]), .digit1(dig[7:4]), .digit2(dig[11:8]), .digit3(dig[15:12]),
        .adj(adj), .sel_pair(sel_pair),
        .numb(numb), .blank(blank), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [15:0] dig;
        logic [3:0]  an;
        logic [3:0]  numb;
        logic        blank;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] i;
        logic       ph;
        logic [3:0] ean;
        logic [3:0] en;
        logic       eb;
        i  = 2'((se / 4) % 4);
        ph = ((bc / 8) % 2) == 1;
        if (run_m) begin
            ean = ~(4'b0001 << i);
            en  = sh_m[i];
            eb  = adj && ph && (sel_pair ? (i >= 2'd2) : (i <= 2'd1));
        end else begin
            ean = 4'b1111;
            en  = 4'd0;
            eb  = 1'b1;
        end
        chk({tag, ".an"}, an, ean);
        chk({tag, ".numb"}, numb, en);
        chk({tag, ".blank"}, {3'b000, blank}, {3'b000, eb});
    endtask

    task automatic capture();
        sh_m[0] = dig[3:0];
        sh_m[1] = dig[7:4];
        sh_m[2] = dig[11:8];
        sh_m[3] = dig[15:12];
    endtask

    // One clock edge: advance the reference with the inputs seen at the edge, then check.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            run_m = 1'b0;
            se = 0;
            bc = 0;
            for (int k = 0; k < 4; k++) sh_m[k] = 4'd0;
        end else begin
            if (!run_m) begin
                run_m = 1'b1;
                se = 0;
                capture();
            end else begin
                se++;
                if (se % 16 == 0) capture();
            end
            bc = adj ? bc + 1 : 0;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'h1234, 4'b1111, 4'd0, 1'b1};
        vecs[1]  = '{1'b0, 16'h1234, 4'b1111, 4'd0, 1'b1};
        vecs[2]  = '{1'b0, 16'h1234, 4'b1111, 4'd0, 1'b1};
        vecs[3]  = '{1'b0, 16'h1234, 4'b1111, 4'd0, 1'b1};
        vecs[4]  = '{1'b0, 16'h1234, 4'b1111, 4'd0, 1'b1};
        vecs[5]  = '{1'b1, 16'h1234, 4'b1110, 4'd4, 1'b0};
        vecs[6]  = '{1'b1, 16'h1234, 4'b1110, 4'd4, 1'b0};
        vecs[7]  = '{1'b1, 16'h1234, 4'b1110, 4'd4, 1'b0};
        vecs[8]  = '{1'b1, 16'h1234, 4'b1110, 4'd4, 1'b0};
        vecs[9]  = '{1'b1, 16'h1234, 4'b1101, 4'd3, 1'b0};
        vecs[10] = '{1'b1, 16'h1234, 4'b1101, 4'd3, 1'b0};
        vecs[11] = '{1'b1, 16'h1234, 4'b1101, 4'd3, 1'b0};
        vecs[12] = '{1'b1, 16'h1234, 4'b1101, 4'd3, 1'b0};
        vecs[13] = '{1'b1, 16'h1234, 4'b1011, 4'd2, 1'b0};
        vecs[14] = '{1'b1, 16'h1234, 4'b1011, 4'd2, 1'b0};
        vecs[15] = '{1'b1, 16'h1234, 4'b1011, 4'd2, 1'b0};
        vecs[16] = '{1'b1, 16'h1234, 4'b1011, 4'd2, 1'b0};
        vecs[17] = '{1'b1, 16'h1234, 4'b0111, 4'd1, 1'b0};
        vecs[18] = '{1'b1, 16'h1234, 4'b0111, 4'd1, 1'b0};
        vecs[19] = '{1'b1, 16'h1234, 4'b0111, 4'd1, 1'b0};
        vecs[20] = '{1'b1, 16'h1234, 4'b0111, 4'd1, 1'b0};
        vecs[21] = '{1'b1, 16'h1234, 4'b1110, 4'd4, 1'b0};

        for (int v = 0; v < 22; v++) begin
            rst_n = vecs[v].rst_n;
            dig   = vecs[v].dig;
            if (v == 5) begin
                #1;
                chk("first_cycle_out.an", an, 4'b1111);
                chk("first_cycle_out.blank", {3'b000, blank}, 4'b0001);
            end
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.an", v), an, vecs[v].an);
            chk($sformatf("vec%0d.numb", v), numb, vecs[v].numb);
            chk($sformatf("vec%0d.blank", v), {3'b000, blank}, {3'b000, vecs[v].blank});
        end

        // Reference now sits at the start of the second frame.
        run_m = 1'b1;
        se = 16;
        bc = 0;
        sh_m[0] = 4'd4; sh_m[1] = 4'd3; sh_m[2] = 4'd2; sh_m[3] = 4'd1;

        // No tearing: digit2 changes while idx=1.
        repeat (4) tick("tear_pre");
        dig = 16'h1934;
        repeat (4) tick("tear_mid");
        chk("tear_hold", numb, 4'd2);
        repeat (16) tick("tear_post");
        chk("tear_new", numb, 4'd9);

        // Blink low pair.
        adj = 1'b1;
        sel_pair = 1'b0;
        #1;
        check_all("adj_rise");
        repeat (26) tick("blink_low");
        chk("blink_low_blanked", {3'b000, blank}, 4'b0001);
        sel_pair = 1'b1;
        #1;
        chk("sel_flip_unblank", {3'b000, blank}, 4'b0000);
        sel_pair = 1'b0;
        #1;
        chk("sel_back_blank", {3'b000, blank}, 4'b0001);

        // Adj drop in the blanked phase, then reassert.
        adj = 1'b0;
        #1;
        chk("adj_drop", {3'b000, blank}, 4'b0000);
        tick("adj_low");
        adj = 1'b1;
        #1;
        check_all("adj_reassert");
        repeat (16) tick("blink_again");

        // Blink high pair.
        sel_pair = 1'b1;
        repeat (16) tick("blink_high");
        adj = 1'b0;
        sel_pair = 1'b0;
        tick("adj_off");

        // Reset mid-frame while idx=2.
        for (int k = 0; k < 16 && ((se / 4) % 4) != 2; k++) tick("seek_idx2");
        chk("at_idx2", an, 4'b1011);
        rst_n = 1'b0;
        dig = 16'h1937;
        tick("mid_reset");
        chk("mid_reset.an", an, 4'b1111);
        rst_n = 1'b1;
        #1;
        check_all("mid_release");
        tick("restart");
        chk("restart.an", an, 4'b1110);
        chk("restart.numb", numb, 4'd7);
        repeat (4) tick("restart_scan");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
